// File: rtl/pwm_ramp_ctrl.sv
// Duty/direction ramp sequencer for an 8-bit free-running PWM generator.
// Duty and direction move only on PWM period boundaries; reversals pass through zero duty and a dead-time.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | duty and dir match the stored target, holding
// S_UP   | ramping duty up toward the stored target
// S_DOWN | ramping duty down toward the target, or toward 0 for a reversal
// S_DEAD | duty forced to 0 while dead_cnt counts boundaries (reversal or estop)
module pwm_ramp_ctrl #(
  parameter int unsigned STEP         = 4,
  parameter int unsigned RAMP_DIV     = 1,
  parameter int unsigned DEAD_PERIODS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tgt_duty,
  input  logic       tgt_dir,
  input  logic       tgt_vld,
  output logic       tgt_rdy,
  input  logic       estop,
  output logic [7:0] duty,
  output logic       dir,
  output logic       at_target,
  output logic       period_tick
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_DEAD
  } state_t;

  localparam logic [8:0] C_STEP     = 9'(STEP);
  localparam logic [7:0] C_DIV_LAST = 8'(RAMP_DIV - 1);
  localparam logic [7:0] C_DEAD     = 8'(DEAD_PERIODS);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_phase;
  logic [7:0] r_div;
  logic [7:0] r_dead_cnt;
  logic [7:0] w_dead_nxt;
  logic [7:0] r_tgt_q;
  logic       r_dir_q;
  logic [7:0] r_duty;
  logic [7:0] w_duty_nxt;
  logic       r_dir;
  logic       w_dir_nxt;

  logic       w_bnd;
  logic       w_acc;
  logic       w_step;
  logic       w_rev;
  logic [7:0] w_goal;
  logic [8:0] w_up_gap;
  logic [8:0] w_dn_gap;
  logic [7:0] w_up_val;
  logic [7:0] w_dn_val;

  assign w_bnd  = (r_phase == 8'hFF);
  assign w_acc  = tgt_vld && tgt_rdy;
  assign w_step = w_bnd && (r_div == C_DIV_LAST);
  assign w_rev  = (r_dir_q != r_dir);
  assign w_goal = w_rev ? 8'd0 : r_tgt_q;

  // 9-bit gaps so a step that would pass the goal saturates onto it instead of wrapping
  assign w_up_gap = {1'b0, w_goal} - {1'b0, r_duty};
  assign w_dn_gap = {1'b0, r_duty} - {1'b0, w_goal};
  assign w_up_val = (w_up_gap <= C_STEP) ? w_goal : 8'({1'b0, r_duty} + C_STEP);
  assign w_dn_val = (w_dn_gap <= C_STEP) ? w_goal : 8'({1'b0, r_duty} - C_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= 8'd0;
    end else begin
      r_phase <= r_phase + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= 8'd0;
    end else if (w_acc) begin
      r_div <= 8'd0;
    end else if (w_bnd) begin
      r_div <= (r_div == C_DIV_LAST) ? 8'd0 : r_div + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tgt_q <= 8'd0;
      r_dir_q <= 1'b0;
    end else if (w_acc) begin
      r_tgt_q <= tgt_duty;
      r_dir_q <= tgt_dir;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_duty     <= 8'd0;
      r_dir      <= 1'b0;
      r_dead_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_duty     <= w_duty_nxt;
      r_dir      <= w_dir_nxt;
      r_dead_cnt <= w_dead_nxt;
    end
  end

  // IDLE/UP/DOWN all re-derive their direction from the current goal each boundary,
  // so a retarget mid-ramp turns around without overshooting.
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_dir_nxt   = r_dir;
    w_dead_nxt  = r_dead_cnt;
    if (estop) begin
      w_state_nxt = S_DEAD;
      w_duty_nxt  = 8'd0;
      w_dead_nxt  = C_DEAD;
    end else if (w_bnd) begin
      case (r_state)
        S_DEAD: begin
          if (r_dead_cnt <= 8'd1) begin
            w_dead_nxt  = 8'd0;
            w_dir_nxt   = r_dir_q;
            w_state_nxt = (r_tgt_q == 8'd0) ? S_IDLE : S_UP;
          end else begin
            w_dead_nxt = r_dead_cnt - 8'd1;
          end
        end
        default: begin
          if (r_duty == w_goal) begin
            if (w_rev) begin
              w_state_nxt = S_DEAD;
              w_dead_nxt  = C_DEAD;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else if (r_duty < w_goal) begin
            w_state_nxt = S_UP;
            if (w_step) begin
              w_duty_nxt = w_up_val;
              if (w_up_val == w_goal) begin
                w_state_nxt = S_IDLE;
              end
            end
          end else begin
            w_state_nxt = S_DOWN;
            if (w_step) begin
              w_duty_nxt = w_dn_val;
              if (w_dn_val == w_goal) begin
                w_state_nxt = w_rev ? S_DEAD : S_IDLE;
                w_dead_nxt  = C_DEAD;
              end
            end
          end
        end
      endcase
    end
  end

  assign duty        = r_duty;
  assign dir         = r_dir;
  assign period_tick = w_bnd;
  assign tgt_rdy     = (r_state != S_DEAD) && !estop;
  assign at_target   = (r_state == S_IDLE) && (r_duty == r_tgt_q) && (r_dir == r_dir_q);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: expected duty/dir/ready/at_target per boundary are
// queued with each command and compared when the DUT signals a period boundary.
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tgt_duty = 8'd0;
  logic       tgt_dir = 1'b0;
  logic       tgt_vld = 1'b0;
  logic       tgt_rdy;
  logic       estop = 1'b0;
  logic [7:0] duty;
  logic       dir;
  logic       at_target;
  logic       period_tick;

  pwm_ramp_ctrl #(
    .STEP        (4),
    .RAMP_DIV    (1),
    .DEAD_PERIODS(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tgt_duty   (tgt_duty),
    .tgt_dir    (tgt_dir),
    .tgt_vld    (tgt_vld),
    .tgt_rdy    (tgt_rdy),
    .estop      (estop),
    .duty       (duty),
    .dir        (dir),
    .at_target  (at_target),
    .period_tick(period_tick)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] duty;
    logic       dir;
    logic       rdy;
    logic       at;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  exp_t  e_m;
  string t_m;
  int    n_chk = 0;
  int    n_pass = 0;
  int    cyc;
  int    last_cyc = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic push(input string tag, input int d, input int dr, input int rdy, input int at);
    sb_q.push_back(exp_t'{8'(d), dr != 0, rdy != 0, at != 0});
    tag_q.push_back(tag);
  endtask

  task automatic send(input int d, input int dr, input string tag);
    tgt_duty = 8'(d);
    tgt_dir  = (dr != 0);
    tgt_vld  = 1'b1;
    #1;
    chk({tag, "_rdy_at_cmd"}, int'(tgt_rdy), 1);
    @(posedge clk);
    #1;
    tgt_vld = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 30000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sb_q.size() != 0) begin
      chk({tag, "_timeout_left"}, sb_q.size(), 0);
      sb_q.delete();
      tag_q.delete();
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (!rst && period_tick && sb_q.size() != 0) begin
      #1;
      e_m = sb_q.pop_front();
      t_m = tag_q.pop_front();
      chk({t_m, "_duty"}, int'(duty), int'(e_m.duty));
      chk({t_m, "_dir"}, int'(dir), int'(e_m.dir));
      chk({t_m, "_rdy"}, int'(tgt_rdy), int'(e_m.rdy));
      chk({t_m, "_at"}, int'(at_target), int'(e_m.at));
      last_cyc = cyc;
    end
  end

  // direction may only move while duty sits at zero
  always @(dir) begin
    #1;
    if (!rst) chk("dir_flip_at_zero", int'(duty), 0);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_duty", int'(duty), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_rdy", int'(tgt_rdy), 1);
    chk("rst_at", int'(at_target), 1);
    chk("rst_tick", int'(period_tick), 0);

    // ramp 0 -> 40, command accepted on edge 5
    repeat (4) @(posedge clk);
    #1;
    for (int k = 1; k <= 10; k++) push($sformatf("s1_b%0d", k), 4 * k, 0, 1, int'(k == 10));
    send(40, 0, "s1");
    drain("s1");
    chk("s1_at_edge", last_cyc, 2560);

    // reversal 40/dir0 -> 10/dir1 through zero and dead-time
    for (int k = 1; k <= 9; k++) push($sformatf("s2_dn%0d", k), 40 - 4 * k, 0, 1, 0);
    push("s2_zero", 0, 0, 0, 0);
    push("s2_dead1", 0, 0, 0, 0);
    push("s2_dead2", 0, 1, 1, 0);
    push("s2_up1", 4, 1, 1, 0);
    push("s2_up2", 8, 1, 1, 0);
    push("s2_up3", 10, 1, 1, 1);
    send(10, 1, "s2");
    drain("s2");

    // saturating steps: 10 -> 3 -> 0, then 0 -> 255 without wrap
    push("s3a_b1", 6, 1, 1, 0);
    push("s3a_b2", 3, 1, 1, 1);
    send(3, 1, "s3a");
    drain("s3a");
    push("s3b_b1", 0, 1, 1, 1);
    send(0, 1, "s3b");
    drain("s3b");
    for (int k = 1; k <= 63; k++) push($sformatf("s3c_b%0d", k), 4 * k, 1, 1, 0);
    push("s3c_last", 255, 1, 1, 1);
    send(255, 1, "s3c");
    drain("s3c");

    // asynchronous reset in the middle of a down ramp
    push("s6_b1", 251, 1, 1, 0);
    push("s6_b2", 247, 1, 1, 0);
    push("s6_b3", 243, 1, 1, 0);
    send(100, 1, "s6");
    drain("s6");
    #3 rst = 1'b1;
    #1;
    chk("arst_duty", int'(duty), 0);
    chk("arst_dir", int'(dir), 0);
    chk("arst_rdy", int'(tgt_rdy), 1);
    chk("arst_at", int'(at_target), 1);
    chk("arst_tick", int'(period_tick), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_rel_duty", int'(duty), 0);

    // fresh ramp from 0 toward 200, stopped at 60 by estop
    for (int k = 1; k <= 15; k++) push($sformatf("s5_b%0d", k), 4 * k, 0, 1, 0);
    send(200, 0, "s5");
    drain("s5");
    estop = 1'b1;
    #1;
    chk("estop_rdy_comb", int'(tgt_rdy), 0);
    @(posedge clk);
    #1;
    chk("estop_duty", int'(duty), 0);
    chk("estop_rdy", int'(tgt_rdy), 0);
    chk("estop_at", int'(at_target), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("estop_hold_duty", int'(duty), 0);
    chk("estop_hold_dir", int'(dir), 0);
    chk("estop_hold_rdy", int'(tgt_rdy), 0);
    estop = 1'b0;
    push("s5_dead1", 0, 0, 0, 0);
    push("s5_dead2", 0, 0, 1, 0);
    for (int k = 1; k <= 25; k++) push($sformatf("s5_res%0d", k), 4 * k, 0, 1, 0);
    drain("s5r");

    // retarget 200 -> 50 while at 100: turns down immediately, never above 100
    for (int k = 1; k <= 12; k++) push($sformatf("s4_dn%0d", k), 100 - 4 * k, 0, 1, 0);
    push("s4_last", 50, 0, 1, 1);
    send(50, 0, "s4");
    drain("s4");
    chk("end_rdy", int'(tgt_rdy), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
